// File: rtl/fcpu_pkg.sv
// Shared CPU-wide types and widths: result-bus word layout and the fixed
// client numbering of the common data bus.
package fcpu_pkg;

    localparam int DATA_W    = 32;
    localparam int RSV_ID_W  = 5;
    localparam int CDB_W     = RSV_ID_W + DATA_W;
    localparam int CDB_N_REQ = 4;

    // Fixed slice positions of the functional units on the arbiter's request bus.
    typedef enum logic [1:0] {
        ALU    = 2'd0,
        FPU    = 2'd1,
        MEM    = 2'd2,
        BRANCH = 2'd3
    } cdb_client_t;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_word_t;

    function automatic logic [CDB_W-1:0] make_cdb_word(input logic [RSV_ID_W-1:0] rsv_id,
                                                       input logic [DATA_W-1:0]   data);
        cdb_word_t w;
        w.rsv_id = rsv_id;
        w.data   = data;
        return w;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_encoder.sv
// Combinational round-robin priority encoder: first set request at or after
// ptr, found by scanning a window of N bits in a doubled request vector.
module rr_priority_encoder #(
    parameter  int N        = 4,
    localparam int REQ_ID_W = $clog2(N)
) (
    input  logic [N-1:0]        req,
    input  logic [REQ_ID_W-1:0] ptr,
    output logic [N-1:0]        grant_onehot,
    output logic [REQ_ID_W-1:0] grant_idx,
    output logic                any
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] window;

    // NOTE: every output of a combinational block gets a default before any
    // conditional write, so no path leaves it unassigned and no latch appears.
    always_comb begin
        req2         = {req, req};
        window       = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        // The window [ptr, ptr+N) of the doubled vector covers each requester
        // exactly once, already in priority order, so wrap needs no modulo.
        for (int j = 0; j < 2 * N; j++) begin
            window[j] = req2[j] && (j >= int'(ptr)) && (j < int'(ptr) + N);
        end
        // NOTE: blocking assignments here are intentional; 'any' is read back
        // within the same pass to keep only the first hit.
        for (int j = 0; j < 2 * N; j++) begin
            if (window[j] && !any) begin
                any = 1'b1;
                if (j >= N) begin
                    grant_idx        = REQ_ID_W'(j - N);
                    grant_onehot[j-N] = 1'b1;
                end else begin
                    grant_idx      = REQ_ID_W'(j);
                    grant_onehot[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one functional unit per cycle in
// round-robin order and broadcasts the registered winner to all consumers.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter  int N_REQ    = CDB_N_REQ,
    localparam int REQ_ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   clear,
    input  logic [N_REQ*CDB_W-1:0] req_cdb,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    output logic [CDB_W-1:0]       cdb,
    output logic                   cdb_valid,
    output logic [REQ_ID_W-1:0]    cdb_src
);

    logic [REQ_ID_W-1:0] ptr;
    logic [REQ_ID_W-1:0] grant_idx;
    logic [N_REQ-1:0]    grant_onehot;
    logic                any_req;
    logic                enable;
    logic                accept;
    logic [CDB_W-1:0]    win_word;

    rr_priority_encoder #(.N(N_REQ)) u_enc (
        .req          (req_valid),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any_req)
    );

    // Reset and flush both suppress the handshake in the same cycle.
    assign enable    = nrst & ~clear;
    assign req_ready = enable ? grant_onehot : '0;
    assign accept    = any_req & enable;

    always_comb begin
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_onehot[i]) begin
                win_word = req_cdb[i*CDB_W +: CDB_W];
            end
        end
    end

    function automatic logic [REQ_ID_W-1:0] next_ptr(input logic [REQ_ID_W-1:0] g);
        if (int'(g) == N_REQ - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr       <= '0;
            cdb       <= '0;
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
        end else if (clear) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
        end else if (accept) begin
            cdb       <= win_word;
            cdb_src   <= grant_idx;
            cdb_valid <= 1'b1;
            ptr       <= next_ptr(grant_idx);
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: table-driven grant vectors with a
// scoreboard of expected broadcasts, plus hand sequences for reset and wrap.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N4 = 4;
    localparam int N3 = 3;

    logic                clk;
    logic                nrst;
    logic                clear;
    logic [N4*CDB_W-1:0] req_cdb;
    logic [N4-1:0]       req_valid;
    logic [N4-1:0]       req_ready;
    logic [CDB_W-1:0]    cdb;
    logic                cdb_valid;
    logic [1:0]          cdb_src;

    logic [N3*CDB_W-1:0] req_cdb3;
    logic [N3-1:0]       req_valid3;
    logic [N3-1:0]       req_ready3;
    logic [CDB_W-1:0]    cdb3;
    logic                cdb_valid3;
    logic [1:0]          cdb_src3;

    cdb_arbiter #(.N_REQ(N4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .req_cdb   (req_cdb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .cdb       (cdb),
        .cdb_valid (cdb_valid),
        .cdb_src   (cdb_src)
    );

    cdb_arbiter #(.N_REQ(N3)) dut3 (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .req_cdb   (req_cdb3),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .cdb       (cdb3),
        .cdb_valid (cdb_valid3),
        .cdb_src   (cdb_src3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [CDB_W-1:0] word;
        logic [1:0]       src;
    } sb_t;

    int               n_checks;
    int               n_fail;
    sb_t              sb_q[$];
    logic [CDB_W-1:0] last_word;
    logic [1:0]       last_src;

    function automatic logic [CDB_W-1:0] word_of(input int i);
        return make_cdb_word(RSV_ID_W'(i), DATA_W'(32'hA0 + i));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of the table: drive, check the combinational grant, then
    // check the broadcast that follows the edge against the scoreboard.
    task automatic apply(input vec_t v, input int step);
        sb_t e;
        sb_t got;
        @(negedge clk);
        clear     = v.clr;
        req_valid = v.valid;
        #1;
        check($sformatf("ready[%0d]", step), 64'(req_ready), 64'(v.exp_ready));
        for (int i = 0; i < N4; i++) begin
            if (v.exp_ready[i]) begin
                e.word = word_of(i);
                e.src  = 2'(i);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("cdb_valid[%0d]", step), 64'(cdb_valid), 64'(v.exp_ready != 4'b0));
        if (cdb_valid) begin
            if (sb_q.size() == 0) begin
                check($sformatf("sb_empty[%0d]", step), 64'(1), 64'(0));
            end else begin
                got = sb_q.pop_front();
                check($sformatf("cdb[%0d]", step), 64'(cdb), 64'(got.word));
                check($sformatf("cdb_src[%0d]", step), 64'(cdb_src), 64'(got.src));
                last_word = got.word;
                last_src  = got.src;
            end
        end else begin
            check($sformatf("cdb_hold[%0d]", step), 64'(cdb), 64'(last_word));
            check($sformatf("src_hold[%0d]", step), 64'(cdb_src), 64'(last_src));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        n_checks  = 0;
        n_fail    = 0;
        last_word = '0;
        last_src  = '0;

        for (int i = 0; i < N4; i++) req_cdb[i*CDB_W +: CDB_W] = word_of(i);
        for (int i = 0; i < N3; i++) req_cdb3[i*CDB_W +: CDB_W] = word_of(i);
        req_valid3 = '0;

        // ptr after each row in the trailing comment
        vecs = '{
            '{1'b0, 4'b0000, 4'b0000},   // idle, ptr 0
            '{1'b0, 4'b0000, 4'b0000},   // idle, ptr 0
            '{1'b0, 4'b1111, 4'b0001},   // all requesting: 0 -> ptr 1
            '{1'b0, 4'b1110, 4'b0010},   // 1 -> ptr 2
            '{1'b0, 4'b1100, 4'b0100},   // 2 -> ptr 3
            '{1'b0, 4'b1000, 4'b1000},   // 3 -> ptr 0
            '{1'b0, 4'b0000, 4'b0000},   // pulse train ends
            '{1'b0, 4'b1010, 4'b0010},   // fairness 1/3: 1 -> ptr 2
            '{1'b0, 4'b1010, 4'b1000},   // 3 -> ptr 0
            '{1'b0, 4'b1010, 4'b0010},   // 1 -> ptr 2
            '{1'b0, 4'b1010, 4'b1000},   // 3 -> ptr 0
            '{1'b0, 4'b0100, 4'b0100},   // single requester 2 -> ptr 3
            '{1'b0, 4'b0100, 4'b0100},   // again full throughput -> ptr 3
            '{1'b0, 4'b0101, 4'b0001},   // from ptr 3 wraps to 0 -> ptr 1
            '{1'b0, 4'b0101, 4'b0100},   // 2 -> ptr 3
            '{1'b1, 4'b0110, 4'b0000},   // clear: no grant, ptr 0
            '{1'b0, 4'b0110, 4'b0010},   // first grant after clear is 1
            '{1'b0, 4'b0110, 4'b0100},   // 2 -> ptr 3
            '{1'b0, 4'b0000, 4'b0000}
        };

        // Reset held with every requester asking.
        nrst      = 1'b0;
        clear     = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_cdb", 64'(cdb), 64'(0));
        check("rst_cdb_src", 64'(cdb_src), 64'(0));
        @(negedge clk);
        req_valid = '0;
        nrst      = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Async reset while a word is on the bus; accepting 1 leaves ptr at 2.
        v = '{1'b0, 4'b0010, 4'b0010};
        apply(v, 100);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("arst_cdb", 64'(cdb), 64'(0));
        check("arst_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        nrst      = 1'b1;
        req_valid = '0;
        last_word = '0;
        last_src  = '0;
        v = '{1'b0, 4'b0110, 4'b0010};   // ptr restarted at 0, so 1 wins over 2
        apply(v, 101);
        v = '{1'b0, 4'b0000, 4'b0000};
        apply(v, 102);

        // Three requesters: grant to 2 must wrap the pointer to 0.
        @(negedge clk);
        req_valid3 = 3'b100;
        #1;
        check("n3_ready_a", 64'(req_ready3), 64'(3'b100));
        @(posedge clk);
        #1;
        check("n3_valid_a", 64'(cdb_valid3), 64'(1));
        check("n3_src_a", 64'(cdb_src3), 64'(int'(MEM)));
        check("n3_cdb_a", 64'(cdb3), 64'(word_of(2)));
        @(negedge clk);
        req_valid3 = 3'b101;
        #1;
        check("n3_ready_b", 64'(req_ready3), 64'(3'b001));
        @(posedge clk);
        #1;
        check("n3_src_b", 64'(cdb_src3), 64'(int'(ALU)));
        check("n3_cdb_b", 64'(cdb3), 64'(word_of(0)));
        @(negedge clk);
        req_valid3 = 3'b100;
        #1;
        check("n3_ready_c", 64'(req_ready3), 64'(3'b100));
        @(posedge clk);
        #1;
        check("n3_valid_c", 64'(cdb_valid3), 64'(1));
        check("n3_src_c", 64'(cdb_src3), 64'(2));
        @(negedge clk);
        req_valid3 = '0;
        @(posedge clk);
        #1;
        check("n3_valid_d", 64'(cdb_valid3), 64'(0));

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single common data bus (CDB) among the functional units: ALU, FPU, load/store and branch.
- Each unit offers one result word, tagged with its reservation-station ID, through a valid/ready handshake.
- The arbiter grants at most one unit per cycle in round-robin order and registers the winner.
- The winner is broadcast on `cdb`/`cdb_valid` to every reservation station and the reorder logic.

## Interface
- `N_REQ`, 4: number of requesting units, 2..8.
- `REQ_ID_W`, `$clog2(N_REQ)`: width of the grant index. Localparam.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush (pipeline squash), active-high.
- `req_cdb` in `N_REQ*CDB_W`: requester i owns slice `[i*CDB_W+:CDB_W]`. Format is `{rsv_id[RSV_ID_W], data[DATA_W]}`.
- `req_valid` in `N_REQ`: requester i has a result.
- `req_ready` out `N_REQ`: one-hot or zero. Requester i is accepted this cycle.
- `cdb` out `CDB_W`: registered broadcast word.
- `cdb_valid` out 1: registered broadcast strobe. No back-pressure.
- `cdb_src` out `REQ_ID_W`: index of the requester that produced the current `cdb`.

## Operation
- **Pointer.** The round-robin pointer `ptr` (`REQ_ID_W` bits) names the highest-priority requester. Reset value is 0.
- **Grant search.** The grant is the first i with `req_valid[i]=1`, scanning i = ptr, ptr+1, … mod N_REQ. Wrap-around is required when `N_REQ` is not a power of two; the index goes from N_REQ-1 to 0.
- **Ready.** `req_ready[g]=1` only for the granted g, and only when `nrst=1` and `clear=0`. Otherwise `req_ready` is all zeros. It is combinational from `req_valid` and `ptr`; there is no dependency on `req_cdb`.
- **Accept.** An accept is `req_valid[g] & req_ready[g]`. On an accept the next edge does three things:
  - `cdb <= req_cdb slice g`
  - `cdb_src <= g`
  - `cdb_valid <= 1`, and `ptr <= (g+1) mod N_REQ`
- **No accept.** When there is no accept, `cdb_valid <= 0`, `cdb` and `cdb_src` hold their last values, and `ptr` holds.
- **Requester rules.**
  - A requester must hold `req_valid` and `req_cdb` stable until it is accepted.
  - The arbiter may keep it waiting indefinitely only while others win.
  - Round-robin guarantees service within N_REQ accepts.
- **clear.**
  - The same edge sets `cdb_valid <= 0` and `ptr <= 0`.
  - No grant is issued in the cycle where `clear=1`.
  - `cdb` and `cdb_src` hold.
- **Reset.** `cdb=0`, `cdb_valid=0`, `cdb_src=0`, `ptr=0`, and all `req_ready` are 0, immediately and asynchronously. Reset mid-broadcast drops the in-flight word.
- **Single valid requester.** It is granted every cycle, giving full throughput. `ptr` keeps moving to its index+1.

## Timing
- **Latency.** Accept in cycle t puts the word on `cdb`, with `cdb_valid=1`, during cycle t+1.
- **Pulse width.** `cdb_valid` is a one-cycle pulse per accepted word. Consecutive accepts produce back-to-back pulses, so throughput is 1 word/cycle.
- **Combinational path.** `req_valid` → `req_ready` is combinational within the same cycle. A requester must not derive `req_valid` from `req_ready`.
- **Register boundary.** `cdb`, `cdb_valid` and `cdb_src` are direct flop outputs; there is no combinational path from inputs.
- **Simultaneous events.** When clear and a valid request coincide, clear wins: no `req_ready` and no broadcast. When nrst is low, everything else is ignored.

## Structure
- `fcpu_pkg` already holds `CDB_W`, `RSV_ID_W` and `DATA_W`. Add to `fcpu_pkg`:
  - `CDB_N_REQ`, the number of CDB clients, as a localparam.
  - An enum `cdb_client_t` of fixed indices: ALU=0, FPU=1, MEM=2, BRANCH=3. The top level uses these indices to wire slices.
- One sub-module, `rr_priority_encoder`:
  - Combinational.
  - Inputs `req[N]`, `ptr[REQ_ID_W]`.
  - Outputs `grant_onehot[N]`, `grant_idx`, `any`.
  - Implemented with a double-width masked scan.
- `cdb_arbiter` instantiates it and holds `ptr` and the output flops.

## Test plan
- **Reset and idle.** nrst low with req_valid=4'b1111 → req_ready=0, cdb_valid=0, cdb=0. Release with all idle → cdb_valid stays 0 and ptr stays 0.
- **All requesting.** req_valid=4'b1111 held, each slice = `{id=i, data=32'hA0+i}`, and each requester drops valid after its accept → grants 0,1,2,3 in consecutive cycles. cdb_valid is high 4 cycles starting 1 cycle after the first grant, with cdb_src=0,1,2,3 and data A0..A3.
- **Fairness under sustained load.** Requesters 1 and 3 always valid → grants alternate 1,3,1,3. Requester 1 never wins twice in a row.
- **Wrap-around with N_REQ=3.** Only requester 2 valid, then requesters 0 and 2 valid → after the grant to 2, ptr wraps to 0, so the next grant is 0 and then 2.
- **Clear.** With 4'b0110 valid, assert clear for one cycle → req_ready=0 and the next-cycle cdb_valid=0. The first grant after clear is 1, since ptr=0 and requester 0 is idle.
- **Async reset mid-stream.** Drop nrst between edges while cdb_valid=1 → cdb_valid goes to 0 immediately, before the next edge. After release the first grant starts from ptr=0.
